// File: rtl/cmd_pkg.sv
// Shared types and widths for the command deframer: rx/tx state encodings and the
// byte-to-command join helper.
package cmd_pkg;

   localparam int CMD_W  = 16;
   localparam int BYTE_W = 8;

   typedef enum logic {
      WAIT_HI = 1'b0,
      WAIT_LO = 1'b1
   } rx_state_t;

   typedef enum logic {
      TX_IDLE = 1'b0,
      TX_BUSY = 1'b1
   } tx_state_t;

   // High byte arrives first on the wire and lands in the upper half.
   function automatic logic [CMD_W-1:0] join_bytes(input logic [BYTE_W-1:0] hi,
                                                   input logic [BYTE_W-1:0] lo);
      return {hi, lo};
   endfunction

endpackage

// File: rtl/cmd_deframer_if.sv
// Bundles the UART-side and command-processor-side handshakes of cmd_deframer.
// master = the deframer, slave = its surroundings.
interface cmd_deframer_if;
   import cmd_pkg::*;

   logic [BYTE_W-1:0] rx_data;
   logic              rx_rdy;
   logic              clr_rx_rdy;
   logic [CMD_W-1:0]  cmd;
   logic              cmd_rdy;
   logic              clr_cmd_rdy;
   logic              cmd_ovr;
   logic [BYTE_W-1:0] resp;
   logic              send_resp;
   logic              trmt;
   logic [BYTE_W-1:0] tx_data;
   logic              tx_done;
   logic              resp_sent;
   logic              frame_err;

   modport master (
      input  rx_data, rx_rdy, clr_cmd_rdy, resp, send_resp, tx_done,
      output clr_rx_rdy, cmd, cmd_rdy, cmd_ovr, trmt, tx_data, resp_sent, frame_err
   );

   modport slave (
      output rx_data, rx_rdy, clr_cmd_rdy, resp, send_resp, tx_done,
      input  clr_rx_rdy, cmd, cmd_rdy, cmd_ovr, trmt, tx_data, resp_sent, frame_err
   );

endinterface

// File: rtl/cmd_deframer_tx.sv
// Response-transmit FSM: latches one response byte, kicks the UART transmitter and
// reports completion. Requests arriving while busy are dropped.
module cmd_deframer_tx
   import cmd_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [BYTE_W-1:0] resp,
   input  logic              send_resp,
   input  logic              tx_done,
   output logic              trmt,
   output logic [BYTE_W-1:0] tx_data,
   output logic              resp_sent
);

   tx_state_t         tx_state_r;
   logic              trmt_r;
   logic [BYTE_W-1:0] tx_data_r;
   logic              resp_sent_r;

   // Transmit state machine with registered pulse outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state_r  <= TX_IDLE;
         trmt_r      <= 1'b0;
         tx_data_r   <= 8'h00;
         resp_sent_r <= 1'b0;
      end else begin
         trmt_r      <= 1'b0;
         resp_sent_r <= 1'b0;
         case (tx_state_r)
            TX_IDLE: begin
               if (send_resp) begin
                  tx_data_r  <= resp;
                  trmt_r     <= 1'b1;
                  tx_state_r <= TX_BUSY;
               end
            end
            TX_BUSY: begin
               if (tx_done) begin
                  resp_sent_r <= 1'b1;
                  tx_state_r  <= TX_IDLE;
               end
            end
            default: tx_state_r <= TX_IDLE;
         endcase
      end
   end

   assign trmt      = trmt_r;
   assign tx_data   = tx_data_r;
   assign resp_sent = resp_sent_r;

endmodule

// File: rtl/cmd_deframer.sv
// Receive-side command deframer: joins two UART bytes into a 16-bit command and
// returns response bytes. Inter-byte timeout enabled by CMD_DEFRAMER_TIMEOUT_EN.
module cmd_deframer
   import cmd_pkg::*;
#(
   parameter int TIMEOUT_CLKS = 32'd1_000_000,
   parameter int TO_W         = 32'd20
)(
   input  logic           clk,
   input  logic           rst,
   cmd_deframer_if.master bus
);

   if ((TIMEOUT_CLKS < 32'sd2) || ((64'd1 << TO_W) <= 64'(TIMEOUT_CLKS))) begin : g_cfg_check
      $error("cmd_deframer: TIMEOUT_CLKS must be >= 2 and fit in TO_W bits");
   end

   rx_state_t         rx_state_r;
   logic [BYTE_W-1:0] hi_byte_r;
   logic [CMD_W-1:0]  cmd_r;
   logic              cmd_rdy_r;
   logic              cmd_ovr_r;
   logic              clr_rx_rdy_r;
   logic              rx_armed_r;
   logic              take_s;
   logic              timeout_s;
   logic              trmt_s;
   logic [BYTE_W-1:0] tx_data_s;
   logic              resp_sent_s;

   // rx_armed_r blocks re-consuming a byte whose rx_rdy has not yet dropped.
   assign take_s = bus.rx_rdy & rx_armed_r;

`ifdef CMD_DEFRAMER_TIMEOUT_EN
   logic [TO_W-1:0] to_cnt_r;
   logic            frame_err_r;

   assign timeout_s = (rx_state_r == WAIT_LO) && !bus.rx_rdy &&
                      (to_cnt_r == TO_W'(TIMEOUT_CLKS - 32'sd1));

   // Inter-byte timeout counter; rx_rdy on the expiry cycle wins over the timeout.
   always_ff @(posedge clk) begin
      if (rst) begin
         to_cnt_r    <= '0;
         frame_err_r <= 1'b0;
      end else begin
         frame_err_r <= timeout_s;
         if ((rx_state_r == WAIT_HI) || timeout_s) begin
            to_cnt_r <= '0;
         end else if (!bus.rx_rdy) begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
         end
      end
   end

   assign bus.frame_err = frame_err_r;
`else
   assign timeout_s     = 1'b0;
   assign bus.frame_err = 1'b0;
`endif

   // Byte assembly FSM and command handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state_r   <= WAIT_HI;
         hi_byte_r    <= 8'h00;
         cmd_r        <= 16'h0000;
         cmd_rdy_r    <= 1'b0;
         cmd_ovr_r    <= 1'b0;
         clr_rx_rdy_r <= 1'b0;
         rx_armed_r   <= 1'b1;
      end else begin
         clr_rx_rdy_r <= 1'b0;
         cmd_ovr_r    <= 1'b0;
         if (!bus.rx_rdy) begin
            rx_armed_r <= 1'b1;
         end
         if (bus.clr_cmd_rdy) begin
            cmd_rdy_r <= 1'b0;
         end
         case (rx_state_r)
            WAIT_HI: begin
               if (take_s) begin
                  hi_byte_r    <= bus.rx_data;
                  clr_rx_rdy_r <= 1'b1;
                  rx_armed_r   <= 1'b0;
                  rx_state_r   <= WAIT_LO;
               end
            end
            WAIT_LO: begin
               if (take_s) begin
                  // Completion overrides a same-cycle clr_cmd_rdy.
                  cmd_r        <= join_bytes(hi_byte_r, bus.rx_data);
                  cmd_rdy_r    <= 1'b1;
                  cmd_ovr_r    <= cmd_rdy_r & ~bus.clr_cmd_rdy;
                  clr_rx_rdy_r <= 1'b1;
                  rx_armed_r   <= 1'b0;
                  rx_state_r   <= WAIT_HI;
               end else if (timeout_s) begin
                  hi_byte_r  <= 8'h00;
                  rx_state_r <= WAIT_HI;
               end
            end
            default: rx_state_r <= WAIT_HI;
         endcase
      end
   end

   cmd_deframer_tx u_tx (
      .clk       (clk),
      .rst       (rst),
      .resp      (bus.resp),
      .send_resp (bus.send_resp),
      .tx_done   (bus.tx_done),
      .trmt      (trmt_s),
      .tx_data   (tx_data_s),
      .resp_sent (resp_sent_s)
   );

   assign bus.clr_rx_rdy = clr_rx_rdy_r;
   assign bus.cmd        = cmd_r;
   assign bus.cmd_rdy    = cmd_rdy_r;
   assign bus.cmd_ovr    = cmd_ovr_r;
   assign bus.trmt       = trmt_s;
   assign bus.tx_data    = tx_data_s;
   assign bus.resp_sent  = resp_sent_s;

endmodule
